bus_responder: RTL and testbench

- Target-side endpoint of the bus interface: accepts read/write cycles issued by the interface master over a 20-bit address / 8-bit data bus.
- Services memory space (local byte RAM) and I/O space (4 byte-wide registers).
- Inserts programmable wait states, then returns a single-cycle acknowledge with read data or an error flag.
- Sits on the far side of the bus from the top-level interface block.

---
 rtl/bus_responder.sv | 159 +++++++++++++++
 tb/tb_bus_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_responder.sv
// Bus target endpoint: byte RAM (memory space) plus four byte registers (I/O space), with
// programmable wait states. Define ADDR_CHECK_EN to reject memory addresses beyond the RAM.
module bus_responder #(
    parameter int AW          = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  OP,
    input  logic [19:0] Direction,
    input  logic [7:0]  Data_in,
    output logic        ack,
    output logic        err,
    output logic [7:0]  Data_out,
    output logic        busy
);

    // state | meaning
    // IDLE  | waiting for req; also the cycle in which ack is high
    // WAIT  | counting wait states down to zero
    // RESP  | next edge commits the access and raises ack
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [2:0]  OP_NOP    = 3'b000;
    localparam logic [2:0]  OP_MEM_RD = 3'b001;
    localparam logic [2:0]  OP_MEM_WR = 3'b010;
    localparam logic [2:0]  OP_IO_RD  = 3'b011;
    localparam logic [2:0]  OP_IO_WR  = 3'b100;
    localparam logic [19:0] HI_MASK   = ~((20'd1 << AW) - 20'd1);

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic [2:0]      op_q;
    logic [AW-1:0]   addr_q;
    logic [7:0]      wdata_q;
    logic            ack_q, err_q, busy_q;
    logic [7:0]      dout_q;
    logic [7:0]      io_q [4];
    logic [7:0]      mem  [2**AW];

    logic            accept;
    logic            addr_bad;
    logic            rsp_err_d;
    logic [7:0]      rsp_data_d;
    logic            mem_we_d, io_we_d;

    assign accept = (state_q == S_IDLE) && req;

`ifdef ADDR_CHECK_EN
    logic addr_bad_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            addr_bad_q <= 1'b0;
        else if (accept)
            addr_bad_q <= |(Direction & HI_MASK);
    end
    assign addr_bad = addr_bad_q;
`else
    logic unused_dir_hi;
    assign unused_dir_hi = |(Direction & HI_MASK);
    assign addr_bad      = 1'b0;
`endif

    always_comb begin
        rsp_err_d  = 1'b0;
        rsp_data_d = 8'h00;
        mem_we_d   = 1'b0;
        io_we_d    = 1'b0;
        case (op_q)
            OP_NOP: ;
            OP_MEM_RD: begin
                if (addr_bad) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = 8'hFF;
                end else begin
                    rsp_data_d = mem[addr_q];
                end
            end
            OP_MEM_WR: begin
                if (addr_bad) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = 8'hFF;
                end else begin
                    mem_we_d = (state_q == S_RESP);
                end
            end
            OP_IO_RD: rsp_data_d = io_q[addr_q[1:0]];
            OP_IO_WR: io_we_d = (state_q == S_RESP);
            default: begin
                rsp_err_d  = 1'b1;
                rsp_data_d = 8'hFF;
            end
        endcase
    end

    // RAM is deliberately left out of reset; an aborted cycle never reaches RESP so never writes.
    always_ff @(posedge clk) begin
        if (mem_we_d)
            mem[addr_q] <= wdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= OP_NOP;
            addr_q  <= '0;
            wdata_q <= 8'h00;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= 8'h00;
            busy_q  <= 1'b0;
            for (int i = 0; i < 4; i++)
                io_q[i] <= 8'h00;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        op_q    <= OP;
                        addr_q  <= Direction[AW-1:0];
                        wdata_q <= Data_in;
                        busy_q  <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= 4'(WAIT_CYCLES - 1);
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0)
                        state_q <= S_RESP;
                    else
                        cnt_q <= cnt_q - 4'd1;
                end
                S_RESP: begin
                    ack_q   <= 1'b1;
                    err_q   <= rsp_err_d;
                    dout_q  <= rsp_data_d;
                    state_q <= S_IDLE;
                    if (io_we_d)
                        io_q[addr_q[1:0]] <= wdata_q;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack      = ack_q;
    assign err      = err_q;
    assign Data_out = dout_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: transaction-level model predicts every ack/err/data/busy
// cycle; literal checks pin the model on the key scenarios.
module tb_bus_responder;

    localparam int AW    = 12;
    localparam int W     = 2;
    localparam int MEMSZ = 1 << AW;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [2:0]  OP;
    logic [19:0] Direction;
    logic [7:0]  Data_in;
    logic        ack, err, busy;
    logic [7:0]  Data_out;

    bus_responder #(.AW(AW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .req(req), .OP(OP), .Direction(Direction),
        .Data_in(Data_in), .ack(ack), .err(err), .Data_out(Data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         acc;
        int         ackc;
        logic       e;
        logic [7:0] d;
        logic       chk_d;
    } exp_t;

    exp_t       exp_q[$];
    int         ack_log[$];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_mis = 0;
    int         last_acc = 0;
    int         last_ack_cyc = 0;
    logic       last_err = 1'b0;
    logic [7:0] last_data = 8'h00;
    logic       abort_busy = 1'b0;
    logic [7:0] model_mem [MEMSZ];
    logic [7:0] model_io  [4];

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic exp_ack, exp_busy;
        exp_ack  = 1'b0;
        exp_busy = abort_busy;
        if (exp_q.size() > 0 && cyc >= exp_q[0].acc) exp_busy = 1'b1;
        if (exp_q.size() > 0 && cyc == exp_q[0].ackc) exp_ack = 1'b1;
        chk("ack", ack, exp_ack);
        chk("busy", busy, exp_busy);
        if (exp_ack) begin
            chk("err", err, exp_q[0].e);
            if (exp_q[0].chk_d) chk("data", Data_out, exp_q[0].d);
            void'(exp_q.pop_front());
        end else if (exp_q.size() > 0 && cyc > exp_q[0].ackc) begin
            void'(exp_q.pop_front());
        end
        if (ack) begin
            last_data    = Data_out;
            last_err     = err;
            last_ack_cyc = cyc;
            ack_log.push_back(cyc);
        end
    end

    function automatic void predict(input logic [2:0] op, input logic [19:0] a, input logic [7:0] d,
                                    output logic e, output logic [7:0] q, output logic cd);
        logic hi_bad;
        hi_bad = 1'b0;
`ifdef ADDR_CHECK_EN
        hi_bad = (a >> AW) != 0;
`endif
        e  = 1'b0;
        q  = 8'h00;
        cd = 1'b1;
        case (op)
            3'd0: ;
            3'd1: if (hi_bad) begin e = 1'b1; q = 8'hFF; end else q = model_mem[a % MEMSZ];
            3'd2: if (hi_bad) begin e = 1'b1; q = 8'hFF; end else begin model_mem[a % MEMSZ] = d; cd = 1'b0; end
            3'd3: q = model_io[a % 4];
            3'd4: begin model_io[a % 4] = d; cd = 1'b0; end
            default: begin e = 1'b1; q = 8'hFF; end
        endcase
    endfunction

    // Called just after a rising edge with the DUT idle; it accepts on the next edge.
    task automatic issue(input logic [2:0] op, input logic [19:0] a, input logic [7:0] d);
        logic e, cd;
        logic [7:0] q;
        predict(op, a, d, e, q, cd);
        last_acc = cyc + 1;
        exp_q.push_back('{acc: cyc + 1, ackc: cyc + 2 + W, e: e, d: q, chk_d: cd});
        OP        = op;
        Direction = a;
        Data_in   = d;
        req       = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (exp_q.size() != 0 && n < 40);
        #1;
        chk("idle_timeout", exp_q.size(), 0);
    endtask

    // Inputs are scrambled right after acceptance to show they are latched only once.
    task automatic xact(input logic [2:0] op, input logic [19:0] a, input logic [7:0] d);
        issue(op, a, d);
        @(posedge clk);
        #1;
        req       = 1'b0;
        OP        = 3'b111;
        Direction = ~a;
        Data_in   = ~d;
        wait_idle();
    endtask

    initial begin
        for (int i = 0; i < MEMSZ; i++) model_mem[i] = 8'h00;
        for (int i = 0; i < 4; i++) model_io[i] = 8'h00;
        reset = 1'b0; req = 1'b0; OP = 3'd0; Direction = 20'h0; Data_in = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_ack", ack, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_data", Data_out, 8'h00);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        xact(3'b010, 20'h00123, 8'hA5);
        chk("lat_wr", last_ack_cyc - last_acc, 3);
        xact(3'b001, 20'h00123, 8'h00);
        chk("lat_rd", last_ack_cyc - last_acc, 3);
        chk("rd123", last_data, 8'hA5);
        chk("rd123_err", last_err, 1'b0);

        xact(3'b100, 20'h00002, 8'h3C);
        xact(3'b011, 20'hFFFF2, 8'h00);
        chk("io2", last_data, 8'h3C);
        xact(3'b011, 20'h00000, 8'h00);
        chk("io0", last_data, 8'h00);
        xact(3'b000, 20'h00123, 8'h55);
        chk("nop_data", last_data, 8'h00);

        xact(3'b110, 20'h00123, 8'h5A);
        chk("ill_err", last_err, 1'b1);
        chk("ill_data", last_data, 8'hFF);
        xact(3'b001, 20'h00123, 8'h00);
        chk("ill_ram", last_data, 8'hA5);
        xact(3'b011, 20'h00002, 8'h00);
        chk("ill_io", last_data, 8'h3C);

        ack_log.delete();
        for (int i = 0; i < 4; i++) begin
            issue(3'b010, 20'(i), 8'h10 + 8'(i));
            if (i < 3) begin
                repeat (W + 2) @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        req = 1'b0;
        wait_idle();
        chk("b2b_count", ack_log.size(), 4);
        for (int i = 0; i < 3 && i + 1 < ack_log.size(); i++)
            chk("b2b_gap", ack_log[i + 1] - ack_log[i], 4);
        for (int i = 0; i < 4; i++) begin
            xact(3'b001, 20'(i), 8'h00);
            chk("b2b_rd", last_data, 8'h10 + 8'(i));
        end

        xact(3'b010, 20'h00040, 8'h11);
        ack_log.delete();
        OP = 3'b010; Direction = 20'h00040; Data_in = 8'h77; req = 1'b1;
        @(posedge clk);
        #1;
        req        = 1'b0;
        abort_busy = 1'b1;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        abort_busy = 1'b0;
        for (int i = 0; i < 4; i++) model_io[i] = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_noack", ack_log.size(), 0);
        xact(3'b001, 20'h00040, 8'h00);
        chk("abort_rd", last_data, 8'h11);
        xact(3'b011, 20'h00002, 8'h00);
        chk("abort_io", last_data, 8'h00);

        xact(3'b010, 20'h01040, 8'h99);
`ifdef ADDR_CHECK_EN
        chk("hi_wr_err", last_err, 1'b1);
        xact(3'b001, 20'h00040, 8'h00);
        chk("hi_rd", last_data, 8'h11);
`else
        chk("hi_wr_err", last_err, 1'b0);
        xact(3'b001, 20'h00040, 8'h00);
        chk("hi_rd", last_data, 8'h99);
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
